uart_rx_fifo: RTL

//  Parametrised UART receiver, next generation of the current 8N1 receiver.

---
 rtl/uart_rx_fifo_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receive-side handshake bundle between uart_rx_fifo and its consumer.
//   rx_data   FIFO head data word (0 while rx_valid is low)
//   rx_ferr   head word had a low stop bit
//   rx_perr   head word failed its parity check
//   rx_valid  FIFO holds at least one word
//   rx_ready  consumer takes the head word this cycle
// master = receiver side, slave = consumer side.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_ferr;
    logic                 rx_perr;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data, rx_ferr, rx_perr, rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_ferr, rx_perr, rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with 3-sample majority voting, false-start
// rejection, per-word frame/parity error tags and a first-word-fall-through
// output FIFO with a sticky overrun flag.
// Ports:
//   clk        system clock
//   rstn       asynchronous reset, active-low
//   uart_rx    serial line, idle high, asynchronous to clk
//   rx         receive handshake (data/ferr/perr/valid out, ready in)
//   overrun_o  sticky: a completed word was dropped because the FIFO was full
//   err_clr_i  synchronous clear of overrun_o (a same-cycle set wins)
//   busy_o     receiver FSM not idle
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              uart_rx,
    uart_rx_fifo_if.master    rx,
    output logic              overrun_o,
    input  logic              err_clr_i,
    output logic              busy_o
);
    localparam int BAUD_CLK = CLK_FREQ / BAUD_RATE;
    localparam int MID      = BAUD_CLK / 2;
    localparam int CW       = $clog2(BAUD_CLK);
    localparam int IW       = $clog2(DATA_BITS + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int EW       = DATA_BITS + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_n;
    logic                 sync1, sync2, edge_q;
    logic                 start_edge;
    logic [CW-1:0]        cnt;
    logic [1:0]           smp;
    logic                 voted;
    logic                 at_m1, at_mid, decide, wrap;
    logic [IW-1:0]        bit_idx;
    logic [0:0]           stop_idx;
    logic                 last_stop;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_exp;
    logic                 perr_q, ferr_q;
    logic                 push;
    logic [EW-1:0]        word;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 empty, full, pop, wr_en;
    logic [EW-1:0]        head;

    // Two-flop synchroniser plus one edge flop; all idle high out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            edge_q <= 1'b1;
        end else begin
            sync1  <= uart_rx;
            sync2  <= sync1;
            edge_q <= sync2;
        end
    end

    assign start_edge = edge_q & ~sync2;

    assign at_m1  = (cnt == CW'(MID - 1));
    assign at_mid = (cnt == CW'(MID));
    assign decide = (cnt == CW'(MID + 1));
    assign wrap   = (cnt == CW'(BAUD_CLK - 1));

    // Third sample is the live synchroniser output at the decision count.
    assign voted = (smp[0] & smp[1]) | (smp[0] & sync2) | (smp[1] & sync2);

    assign par_exp   = (PARITY == 1) ? ~(^shreg) : (^shreg);
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
    assign word      = {perr_q, ferr_q | ~voted, shreg};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        push    = 1'b0;
        case (state)
            IDLE:  if (start_edge) state_n = START;
            START: begin
                if (decide && voted) state_n = IDLE;
                else if (wrap)       state_n = DATA;
            end
            DATA:  if (wrap && bit_idx == IW'(DATA_BITS))
                       state_n = (PARITY != 0) ? PAR : STOP;
            PAR:   if (wrap) state_n = STOP;
            // Leave at the decision point of the last stop bit so that a
            // start bit following immediately is not missed.
            STOP:  if (decide && last_stop) begin
                       push    = 1'b1;
                       state_n = IDLE;
                   end
            default: state_n = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            smp      <= '0;
            bit_idx  <= '0;
            stop_idx <= '0;
            shreg    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            if (state == IDLE || state_n == IDLE) cnt <= '0;
            else if (wrap)                        cnt <= '0;
            else                                  cnt <= cnt + 1'b1;

            if (at_m1)  smp[0] <= sync2;
            if (at_mid) smp[1] <= sync2;

            case (state)
                IDLE: begin
                    bit_idx  <= '0;
                    stop_idx <= '0;
                    perr_q   <= 1'b0;
                    ferr_q   <= 1'b0;
                end
                DATA: if (decide) begin
                    shreg   <= {voted, shreg[DATA_BITS-1:1]};
                    bit_idx <= bit_idx + 1'b1;
                end
                PAR: if (decide) perr_q <= (voted != par_exp);
                STOP: if (decide) begin
                    if (!voted) ferr_q <= 1'b1;
                    stop_idx <= stop_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output FIFO: extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && rx.rx_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= word;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) overrun_o <= 1'b1;
            else if (err_clr_i)       overrun_o <= 1'b0;
        end
    end

    assign head        = mem[rd_ptr[AW-1:0]];
    assign rx.rx_valid = !empty;
    assign rx.rx_data  = empty ? '0 : head[DATA_BITS-1:0];
    assign rx.rx_ferr  = empty ? 1'b0 : head[DATA_BITS];
    assign rx.rx_perr  = empty ? 1'b0 : head[DATA_BITS+1];
endmodule
